// File: rtl/banco_entrada.sv
// Four-port four-phase input bank with synchronized req, per-port holding registers and CPU read port.
// Define INPUT_OVERRUN_EN for overwrite mode with sticky overrun flags; default build applies backpressure.
module banco_entrada #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [3:0]       req,
    output logic [3:0]       ack,
    input  logic [1:0]       select,
    input  logic             re,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       valid,
    output logic [3:0]       overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACKED     = 2'd1,
        WAIT_FULL = 2'd2
    } state_t;

    state_t           state_q [4];
    state_t           state_d [4];
    logic [WIDTH-1:0] hold_q  [4];
    logic [WIDTH-1:0] hold_d  [4];
    logic [WIDTH-1:0] in_w    [4];
    logic [3:0]       sync0_q, sync1_q;
    logic [3:0]       ack_q, ack_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       overrun_q, overrun_d;
    logic [3:0]       rd;

    always_comb begin
        in_w[0] = in0;
        in_w[1] = in1;
        in_w[2] = in2;
        in_w[3] = in3;
    end

    // A read only counts on the selected port while it holds data.
    always_comb begin
        rd = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rd[i] = re && (select == 2'(i)) && valid_q[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i]   = state_q[i];
            hold_d[i]    = hold_q[i];
            valid_d[i]   = valid_q[i] & ~rd[i];
            overrun_d[i] = overrun_q[i] & ~rd[i];
            case (state_q[i])
                IDLE: begin
                    if (sync1_q[i]) begin
`ifdef INPUT_OVERRUN_EN
                        hold_d[i]    = in_w[i];
                        valid_d[i]   = 1'b1;
                        overrun_d[i] = valid_q[i] & ~rd[i];
                        state_d[i]   = ACKED;
`else
                        // A read on the capture edge frees the register in time.
                        if (!valid_q[i] || rd[i]) begin
                            hold_d[i]  = in_w[i];
                            valid_d[i] = 1'b1;
                            state_d[i] = ACKED;
                        end else begin
                            state_d[i] = WAIT_FULL;
                        end
`endif
                    end
                end
                ACKED: begin
                    if (!sync1_q[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                WAIT_FULL: begin
                    if (!sync1_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (!valid_q[i]) begin
                        hold_d[i]  = in_w[i];
                        valid_d[i] = 1'b1;
                        state_d[i] = ACKED;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
`ifndef INPUT_OVERRUN_EN
            overrun_d[i] = 1'b0;
`endif
            ack_d[i] = (state_d[i] == ACKED);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            ack_q     <= '0;
            valid_q   <= '0;
            overrun_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                hold_q[i]  <= '0;
            end
        end else begin
            sync0_q   <= req;
            sync1_q   <= sync0_q;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    assign ack     = ack_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign out     = hold_q[select];

endmodule

// File: tb/tb_banco_entrada.sv
// Scoreboard bench for banco_entrada: peripheral handshakes push expected captures, a monitor checks each ack rise.
`timescale 1ns/1ps
module tb_banco_entrada;

`ifdef INPUT_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       ovr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_v [4];
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] select;
    logic       re;
    logic [7:0] out;
    logic [3:0] valid;
    logic [3:0] overrun;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q [4][$];

    logic [7:0] m_hold [4];
    bit         m_full [4];
    bit         m_ovr  [4];

    banco_entrada #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
        .req(req), .ack(ack), .select(select), .re(re),
        .out(out), .valid(valid), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every ack rise must match the oldest expected capture of that port.
    logic [3:0] ack_prev = '0;
    exp_t       mon_e;
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack[i] && !ack_prev[i]) begin
                if (exp_q[i].size() == 0) begin
                    check("unexpected_ack", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    check("sb_valid", 32'(valid[i]), 32'd1);
                    check("sb_overrun", 32'(overrun[i]), 32'(mon_e.ovr));
                    if (mon_e.cyc >= 0) check("sb_ack_latency", 32'(cyc), 32'(mon_e.cyc));
                    if (select == 2'(i)) check("sb_data", 32'(out), 32'(mon_e.d));
                end
            end
        end
        ack_prev = ack;
    end

    task automatic wait_ack(input int p, input logic v);
        int n = 0;
        while (ack[p] !== v && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait", 32'(ack[p]), 32'(v));
    endtask

    task automatic do_release(input int p);
        int k;
        @(negedge clk);
        req[p] = 1'b0;
        k = cyc;
        in_v[p] = 8'($urandom);
        wait_ack(p, 1'b0);
        check("ack_fall_latency", 32'(cyc), 32'(k + 3));
    endtask

    task automatic do_read(input int p);
        @(negedge clk);
        select = 2'(p);
        check("rd_out_before", 32'(out), 32'(m_hold[p]));
        check("rd_valid_before", 32'(valid[p]), 32'(m_full[p]));
        check("rd_ovr_before", 32'(overrun[p]), 32'(m_ovr[p]));
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        check("rd_valid_after", 32'(valid[p]), 32'd0);
        check("rd_ovr_after", 32'(overrun[p]), 32'd0);
        check("rd_out_after", 32'(out), 32'(m_hold[p]));
        m_full[p] = 1'b0;
        m_ovr[p]  = 1'b0;
    endtask

    task automatic do_write(input int p, input logic [7:0] d);
        exp_t e;
        if (m_full[p] && !OVR) do_read(p);
        @(negedge clk);
        select  = 2'(p);
        in_v[p] = d;
        req[p]  = 1'b1;
        e.d   = d;
        e.ovr = OVR && (m_full[p] || m_ovr[p]);
        e.cyc = cyc + 3;
        exp_q[p].push_back(e);
        m_hold[p] = d;
        m_ovr[p]  = e.ovr;
        m_full[p] = 1'b1;
        wait_ack(p, 1'b1);
        do_release(p);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k;
        logic [7:0] d;
        reset  = 1'b1;
        req    = '0;
        re     = 1'b0;
        select = '0;
        for (int p = 0; p < 4; p++) begin
            in_v[p]   = 8'($urandom_range(1, 255));
            m_hold[p] = '0;
            m_full[p] = 1'b0;
            m_ovr[p]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            #1;
            check("rst_out", 32'(out), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Basic handshake and read.
        do_write(2, 8'hA5);
        check("hs_out_sel2", 32'(out), 32'hA5);
        do_write(1, 8'($urandom));
        do_read(1);

        // Second request on a full port 0.
        if (m_full[0]) do_read(0);
        do_write(0, 8'h11);
`ifdef INPUT_OVERRUN_EN
        do_write(0, 8'h22);
        check("ovw_out", 32'(out), 32'h22);
        check("ovw_overrun", 32'(overrun[0]), 32'd1);
        do_read(0);
`else
        @(negedge clk);
        select  = 2'd0;
        in_v[0] = 8'h22;
        req[0]  = 1'b1;
        e.d = 8'h22; e.ovr = 1'b0; e.cyc = -1;
        exp_q[0].push_back(e);
        repeat (6) @(negedge clk);
        check("bp_ack_low", 32'(ack[0]), 32'd0);
        do_read(0);
        @(negedge clk);
        check("bp_ack_after_read", 32'(ack[0]), 32'd1);
        check("bp_out_after_read", 32'(out), 32'h22);
        check("bp_valid_after_read", 32'(valid[0]), 32'd1);
        m_hold[0] = 8'h22;
        m_full[0] = 1'b1;
        do_release(0);
        do_read(0);
`endif

        // Read on port 3 at the very edge that captures new data.
        if (m_full[3]) do_read(3);
        do_write(3, 8'($urandom));
        @(negedge clk);
        d = 8'($urandom);
        select  = 2'd3;
        in_v[3] = d;
        req[3]  = 1'b1;
        k = cyc;
        e.d = d; e.ovr = 1'b0; e.cyc = k + 3;
        exp_q[3].push_back(e);
        m_hold[3] = d; m_full[3] = 1'b1; m_ovr[3] = 1'b0;
        repeat (2) @(negedge clk);
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        check("sim_valid3", 32'(valid[3]), 32'd1);
        check("sim_out3", 32'(out), 32'(d));
        check("sim_ovr3", 32'(overrun[3]), 32'd0);
        do_release(3);

        // All four ports request together.
        for (int p = 0; p < 4; p++) if (m_full[p]) do_read(p);
        @(negedge clk);
        select = 2'd2;
        k = cyc;
        for (int p = 0; p < 4; p++) begin
            in_v[p] = 8'($urandom);
            e.d = in_v[p]; e.ovr = 1'b0; e.cyc = k + 3;
            exp_q[p].push_back(e);
            m_hold[p] = in_v[p]; m_full[p] = 1'b1;
        end
        req = 4'hF;
        repeat (2) @(negedge clk);
        check("all4_ack_early", 32'(ack), 32'd0);
        @(negedge clk);
        check("all4_ack", 32'(ack), 32'hF);
        req = '0;
        repeat (3) @(negedge clk);
        check("all4_ack_fall", 32'(ack), 32'd0);
        for (int p = 0; p < 4; p++) do_read(p);

        // Reset in the middle of an acknowledged handshake on port 1.
        @(negedge clk);
        d = 8'($urandom_range(1, 255));
        select  = 2'd1;
        in_v[1] = d;
        req[1]  = 1'b1;
        e.d = d; e.ovr = 1'b0; e.cyc = cyc + 3;
        exp_q[1].push_back(e);
        wait_ack(1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ack", 32'(ack[1]), 32'd0);
        check("rst_mid_valid", 32'(valid[1]), 32'd0);
        check("rst_mid_out", 32'(out), 32'd0);
        for (int p = 0; p < 4; p++) begin
            m_hold[p] = '0; m_full[p] = 1'b0; m_ovr[p] = 1'b0;
        end
        @(negedge clk);
        k = cyc;
        e.d = d; e.ovr = 1'b0; e.cyc = k + 3;
        exp_q[1].push_back(e);
        m_hold[1] = d; m_full[1] = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        wait_ack(1, 1'b1);
        check("rst_recapture_latency", 32'(cyc), 32'(k + 3));
        do_release(1);
        do_read(1);

        // Randomized mix of peripheral writes and CPU reads.
        for (int n = 0; n < 60; n++) begin
            int p;
            p = int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) do_write(p, 8'($urandom));
            else do_read(p);
        end

        repeat (5) @(negedge clk);
        for (int p = 0; p < 4; p++) check("sb_leftover", 32'(exp_q[p].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
